dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl_pkg.sv | 8 +
 rtl/dcache_tag_shadow.sv | 17 +
 rtl/dcache_ctrl.sv | 125 ++++++++++++
 tb/tb_dcache_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// dcache_ctrl_pkg: shared line geometry and FSM state encoding for the data-cache controller
package dcache_ctrl_pkg;
  localparam int LINE_W = 512;
  localparam int OFFSET_BITS = 4;
  localparam int INDEX_BITS = 10;
  localparam int TAG_BITS = 18;
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_CHECK, S_WB, S_FILL, S_LOAD, S_DONE} state_e;
endpackage

// File: rtl/dcache_tag_shadow.sv
// dcache_tag_shadow: 1024 x 18 tag copy of the cache, one write port and one async read port
// Ports: clk, rst_n (async, active-low, clears all tags); we_i/widx_i/wtag_i write; ridx_i -> rtag_o read.
module dcache_tag_shadow import dcache_ctrl_pkg::*; (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] widx_i,
  input  logic [TAG_BITS-1:0]   wtag_i,
  input  logic [INDEX_BITS-1:0] ridx_i,
  output logic [TAG_BITS-1:0]   rtag_o
);
  logic [TAG_BITS-1:0] tag_q [2**INDEX_BITS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 2**INDEX_BITS; i++) tag_q[i] <= '0;
    else if (we_i) tag_q[widx_i] <= wtag_i;
  assign rtag_o = tag_q[ridx_i];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: blocking data-cache controller sequencing lookup, writeback, line fill and one retry per request
// Ports: cpu_* request/response; c_* cache command and registered cache response; mem_* line fetch/writeback
// handshake (request held until mem_ack_i); hit/miss/wb saturating counters and sticky err_o.
module dcache_ctrl import dcache_ctrl_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = dcache_ctrl_pkg::LINE_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_busy_o,
  output logic              cpu_done_o,
  output logic              c_en_o,
  output logic              c_rd_o,
  output logic              c_wr_o,
  output logic              c_ld_o,
  output logic [ADDR_W-1:0] c_addr_o,
  output logic [31:0]       c_dataIn_o,
  output logic [LINE_W-1:0] c_blkIn_o,
  input  logic [31:0]       c_dataOut_i,
  input  logic              c_hit_i,
  input  logic              c_miss_i,
  input  logic              c_evict_i,
  input  logic [LINE_W-1:0] c_blkOut_i,
  output logic              mem_rd_req_o,
  output logic              mem_wr_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o,
  output logic [CNT_W-1:0]  wb_cnt_o,
  output logic              err_o
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, wb_addr_q, fill_addr;
  logic [31:0] wdata_q, rdata_q;
  logic [LINE_W-1:0] line_q;
  logic [CNT_W-1:0] hit_q, miss_q, wb_q;
  logic wr_q, retry_q, err_q, hit, look, load;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag, shadow_tag;
  assign idx = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign tag = addr_q[OFFSET_BITS+INDEX_BITS +: TAG_BITS];
  assign fill_addr = ADDR_W'({tag, idx, {OFFSET_BITS{1'b0}}});
  // a contradictory hit+miss response is treated as a miss
  assign hit = c_hit_i & ~c_miss_i;
  assign look = state_q == S_LOOKUP;
  assign load = state_q == S_LOAD;
  dcache_tag_shadow u_shadow (
    .clk(clk), .rst_n(rst_n), .we_i(load), .widx_i(idx), .wtag_i(tag), .ridx_i(idx), .rtag_o(shadow_tag)
  );
  always_comb
    case (state_q)
      S_IDLE:   state_d = (cpu_rd_i | cpu_wr_i) ? S_LOOKUP : S_IDLE;
      S_LOOKUP: state_d = S_CHECK;
      // a miss on the retry lookup ends the request instead of fetching again
      S_CHECK:  state_d = (hit | retry_q) ? S_DONE : c_evict_i ? S_WB : S_FILL;
      S_WB:     state_d = mem_ack_i ? S_FILL : S_WB;
      S_FILL:   state_d = mem_ack_i ? S_LOAD : S_FILL;
      S_LOAD:   state_d = S_LOOKUP;
      default:  state_d = S_IDLE;
    endcase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wb_addr_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      line_q    <= '0;
      hit_q     <= '0;
      miss_q    <= '0;
      wb_q      <= '0;
      wr_q      <= 1'b0;
      retry_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && (cpu_rd_i | cpu_wr_i)) begin
        addr_q  <= cpu_addr_i;
        wdata_q <= cpu_wdata_i;
        wr_q    <= ~cpu_rd_i;
      end
      if (state_q == S_CHECK) begin
        if (hit) begin
          if (!wr_q) rdata_q <= c_dataOut_i;
          if (!retry_q) hit_q <= hit_q + CNT_W'(~&hit_q);
        end else if (retry_q) err_q <= 1'b1;
        else begin
          miss_q    <= miss_q + CNT_W'(~&miss_q);
          line_q    <= c_blkOut_i;
          wb_addr_q <= ADDR_W'({shadow_tag, idx, {OFFSET_BITS{1'b0}}});
        end
      end
      if (state_q == S_WB && mem_ack_i) wb_q <= wb_q + CNT_W'(~&wb_q);
      if (state_q == S_FILL && mem_ack_i) line_q <= mem_rdata_i;
      if (load) retry_q <= 1'b1;
      if (state_q == S_DONE) retry_q <= 1'b0;
    end
  assign cpu_rdata_o  = rdata_q;
  assign cpu_busy_o   = state_q != S_IDLE;
  assign cpu_done_o   = state_q == S_DONE;
  assign c_en_o       = look | load;
  assign c_rd_o       = look & ~wr_q;
  assign c_wr_o       = look & wr_q;
  assign c_ld_o       = load;
  assign c_addr_o     = (look | load) ? addr_q : '0;
  assign c_dataIn_o   = look ? wdata_q : '0;
  assign c_blkIn_o    = load ? line_q : '0;
  assign mem_rd_req_o = state_q == S_FILL;
  assign mem_wr_req_o = state_q == S_WB;
  assign mem_addr_o   = mem_wr_req_o ? wb_addr_q : mem_rd_req_o ? fill_addr : '0;
  assign mem_wdata_o  = mem_wr_req_o ? line_q : '0;
  assign hit_cnt_o    = hit_q;
  assign miss_cnt_o   = miss_q;
  assign wb_cnt_o     = wb_q;
  assign err_o        = err_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench with behavioural cache and memory models around dcache_ctrl
module tb_dcache_ctrl;
  localparam int CW = 3;
  logic clk = 0, rst_n = 0;
  logic cpu_rd = 0, cpu_wr = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
  logic cpu_busy, cpu_done;
  logic c_en, c_rd, c_wr, c_ld;
  logic [31:0] c_addr, c_dataIn, c_dataOut = 0;
  logic c_hit = 0, c_miss = 0, c_evict = 0;
  logic [511:0] c_blkIn, c_blkOut = '0, mem_wdata, mem_rdata = '0;
  logic mem_rd_req, mem_wr_req, mem_ack = 0;
  logic [31:0] mem_addr;
  logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;
  logic err;
  dcache_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_rd_i(cpu_rd), .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_busy_o(cpu_busy), .cpu_done_o(cpu_done),
    .c_en_o(c_en), .c_rd_o(c_rd), .c_wr_o(c_wr), .c_ld_o(c_ld), .c_addr_o(c_addr), .c_dataIn_o(c_dataIn),
    .c_blkIn_o(c_blkIn), .c_dataOut_i(c_dataOut), .c_hit_i(c_hit), .c_miss_i(c_miss), .c_evict_i(c_evict),
    .c_blkOut_i(c_blkOut), .mem_rd_req_o(mem_rd_req), .mem_wr_req_o(mem_wr_req), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .hit_cnt_o(hit_cnt),
    .miss_cnt_o(miss_cnt), .wb_cnt_o(wb_cnt), .err_o(err)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] rdata; int cyc; int lat;} exp_t;
  exp_t sb[$];
  int n_tests = 0, n_fail = 0, cyc = 0, dones = 0;
  int fill_dly = 1, wb_dly = 1, mcnt = 0, rd_reqs = 0, wr_reqs = 0, wr_seen = 0, ld_seen = 0;
  logic [31:0] last_rd = 0, last_rd_addr = 0, last_wr_addr = 0;
  logic [511:0] last_wdata = '0;
  logic [31:0] gold [logic [31:0]];
  logic [511:0] mem_store [logic [31:0]];
  logic [511:0] cl [1024];
  logic [17:0] ct [1024];
  bit cv [1024], cd [1024];
  bit force_miss = 0, prev_done = 0, h;
  logic [9:0] ix;
  exp_t e_mon;
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction
  function automatic logic [31:0] gword(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : pat(a);
  endfunction
  function automatic logic [511:0] gline(input logic [31:0] l);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = gword(l | i);
    return r;
  endfunction
  function automatic logic [511:0] mem_line(input logic [31:0] l);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = pat(l | i);
    return mem_store.exists(l) ? mem_store[l] : r;
  endfunction
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (c_en && (c_rd || c_wr)) begin
      ix = c_addr[13:4];
      h = cv[ix] && ct[ix] == c_addr[31:14] && !force_miss;
      c_hit = h;
      c_miss = !h;
      c_evict = !h && cv[ix] && cd[ix];
      c_blkOut = cl[ix];
      c_dataOut = cl[ix][{c_addr[3:0], 5'b0} +: 32];
      if (c_wr) wr_seen++;
      if (h && c_wr) begin
        cl[ix][{c_addr[3:0], 5'b0} +: 32] = c_dataIn;
        cd[ix] = 1;
      end
    end
    if (c_en && c_ld) begin
      ix = c_addr[13:4];
      cl[ix] = c_blkIn;
      ct[ix] = c_addr[31:14];
      cv[ix] = 1;
      cd[ix] = 0;
      ld_seen++;
    end
  end
  always @(negedge clk) begin
    if (!rst_n || !(mem_rd_req || mem_wr_req)) begin
      mcnt = 0;
      mem_ack = 0;
    end else begin
      mcnt++;
      mem_ack = mcnt == (mem_wr_req ? wb_dly : fill_dly);
      if (mem_ack) begin
        mcnt = 0;
        if (mem_wr_req) begin
          mem_store[mem_addr] = mem_wdata;
          last_wr_addr = mem_addr;
          last_wdata = mem_wdata;
          wr_reqs++;
        end else begin
          mem_rdata = mem_line(mem_addr);
          last_rd_addr = mem_addr;
          rd_reqs++;
        end
      end
    end
  end
  always @(negedge clk) begin
    check("mem_req_excl", mem_rd_req & mem_wr_req, 0);
    check("cmd_onehot", $countones({c_rd, c_wr, c_ld}) <= 1, 1);
    check("done_pulse", cpu_done & prev_done, 0);
    prev_done = cpu_done;
    if (rst_n && cpu_done) begin
      dones++;
      if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
      else begin
        e_mon = sb.pop_front();
        check("rdata", cpu_rdata, e_mon.rdata);
        check("latency", cyc - e_mon.cyc, e_mon.lat);
      end
    end
  end
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input int fd, input int wbd, input int lat, input bit bad);
    exp_t e;
    int d0;
    fill_dly = fd;
    wb_dly = wbd;
    for (int i = 0; i < 100 && cpu_busy; i++) @(negedge clk);
    if (rd && !bad) last_rd = gword(a);
    else if (!rd && wr) gold[a] = wd;
    e.rdata = last_rd;
    e.cyc = cyc;
    e.lat = lat;
    sb.push_back(e);
    d0 = dones;
    cpu_rd = rd;
    cpu_wr = wr;
    cpu_addr = a;
    cpu_wdata = wd;
    @(negedge clk);
    cpu_rd = 0;
    cpu_wr = 0;
    for (int i = 0; i < 300 && dones == d0; i++) @(negedge clk);
    if (dones == d0) begin
      check("done_timeout", dones, d0 + 1);
      sb.delete();
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int r0, l0, w0, d0;
    repeat (3) @(negedge clk);
    check("rst_busy", cpu_busy, 0);
    check("rst_mem_rd", mem_rd_req, 0);
    check("rst_c_en", c_en, 0);
    check("rst_cnts", {hit_cnt, miss_cnt, wb_cnt, err}, 0);
    check("rst_rdata", cpu_rdata, 0);
    rst_n = 1;
    issue(1, 0, 32'h10, 0, 3, 1, 9, 0);
    check("cold_miss_cnt", miss_cnt, 1);
    check("cold_hit_cnt", hit_cnt, 0);
    issue(1, 0, 32'h10, 0, 1, 1, 3, 0);
    check("hit_cnt1", hit_cnt, 1);
    l0 = ld_seen;
    issue(1, 0, 32'h4020, 0, 5, 1, 11, 0);
    check("fill_addr", last_rd_addr, 32'h4020);
    check("fill_ld", ld_seen - l0, 1);
    check("miss_cnt2", miss_cnt, 2);
    check("wb_cnt0", wb_cnt, 0);
    issue(0, 1, 32'h4025, 32'hDEAD_BEEF, 1, 1, 3, 0);
    check("wr_hit_cnt", hit_cnt, 2);
    issue(0, 1, 32'h4_4020, 32'h1234_5678, 4, 2, 12, 0);
    check("wb_addr", last_wr_addr, 32'h4020);
    check("wb_data", last_wdata, gline(32'h4020));
    check("wb_fill_addr", last_rd_addr, 32'h4_4020);
    check("wb_cnt1", wb_cnt, 1);
    issue(1, 0, 32'h4025, 0, 3, 3, 12, 0);
    check("wb2_addr", last_wr_addr, 32'h4_4020);
    check("wb2_data", last_wdata, gline(32'h4_4020));
    check("wb_cnt2", wb_cnt, 2);
    w0 = wr_seen;
    issue(1, 1, 32'h10, 32'hBAD0_BAD0, 1, 1, 3, 0);
    check("rd_prio_no_wr", wr_seen - w0, 0);
    force_miss = 1;
    r0 = rd_reqs;
    d0 = dones;
    issue(1, 0, 32'h8030, 0, 2, 1, 8, 1);
    force_miss = 0;
    check("err_set", err, 1);
    check("err_one_fill", rd_reqs - r0, 1);
    check("err_one_done", dones - d0, 1);
    check("miss_cnt5", miss_cnt, 5);
    for (int i = 0; i < 8; i++) issue(1, 0, 32'h10, 0, 1, 1, 3, 0);
    check("hit_sat", hit_cnt, 7);
    check("err_sticky", err, 1);
    fill_dly = 50;
    cpu_rd = 1;
    cpu_addr = 32'hC000;
    @(negedge clk);
    cpu_rd = 0;
    for (int i = 0; i < 20 && !mem_rd_req; i++) @(negedge clk);
    check("fill_started", mem_rd_req, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_mem_rd", mem_rd_req, 0);
    check("arst_busy", cpu_busy, 0);
    check("arst_cnts", {hit_cnt, miss_cnt, wb_cnt, err}, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    last_rd = 0;
    issue(1, 0, 32'h10, 0, 1, 1, 3, 0);
    check("post_rst_hit", hit_cnt, 1);
    check("post_rst_miss", miss_cnt, 0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
